// File: rtl/fb_pkg.sv
// +----------------------------------------------------------------------+
// | fb_pkg : shared framebuffer geometry and rectangle-fill state type   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fb_pkg;

    localparam int COORD_W_DEF = 8;
    localparam int DATA_W_DEF  = 16;
    localparam int FB_SIZE     = 2 ** COORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/rect_clip.sv
// +----------------------------------------------------------------------+
// | rect_clip : clipped inclusive end coordinates and empty flag         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rect_clip
    import fb_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] x_end,
    output logic [COORD_W-1:0] y_end,
    output logic               empty
);

    localparam logic [COORD_W:0] c_coord_max = {1'b0, {COORD_W{1'b1}}};
    localparam logic [COORD_W:0] c_one       = {{COORD_W{1'b0}}, 1'b1};

    logic [COORD_W:0] w_x_sum;
    logic [COORD_W:0] w_y_sum;

    // One extra bit keeps x0+w-1 from wrapping before the clamp; with a zero
    // size the sum is meaningless but the empty flag overrides it.
    always_comb begin
        w_x_sum = {1'b0, x0} + {1'b0, w} - c_one;
        w_y_sum = {1'b0, y0} + {1'b0, h} - c_one;
        x_end   = (w_x_sum > c_coord_max) ? c_coord_max[COORD_W-1:0] : w_x_sum[COORD_W-1:0];
        y_end   = (w_y_sum > c_coord_max) ? c_coord_max[COORD_W-1:0] : w_y_sum[COORD_W-1:0];
        empty   = (w == '0) || (h == '0);
    end

endmodule

`default_nettype wire

// File: rtl/rect_fill_writer.sv
// +----------------------------------------------------------------------+
// | rect_fill_writer : raster-order solid rectangle fill into RAM port A |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rect_fill_writer
    import fb_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [COORD_W-1:0]   cmd_x0,
    input  logic [COORD_W-1:0]   cmd_y0,
    input  logic [COORD_W-1:0]   cmd_w,
    input  logic [COORD_W-1:0]   cmd_h,
    input  logic [DATA_W-1:0]    cmd_color,
    output logic [2*COORD_W-1:0] mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic                 mem_wren,
    output logic                 busy,
    output logic                 done
);

    fill_state_e          state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d;
    logic [COORD_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]   x0_q, x0_d;
    logic [COORD_W-1:0]   x_end_q, x_end_d;
    logic [COORD_W-1:0]   y_end_q, y_end_d;
    logic [DATA_W-1:0]    color_q, color_d;
    logic [2*COORD_W-1:0] addr_q, addr_d;
    logic                 wren_q, wren_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;

    logic [COORD_W-1:0]   w_clip_x_end;
    logic [COORD_W-1:0]   w_clip_y_end;
    logic                 w_clip_empty;
    logic                 w_accept;
    logic                 w_last;

    rect_clip #(
        .COORD_W (COORD_W)
    ) u_rect_clip (
        .x0    (cmd_x0),
        .y0    (cmd_y0),
        .w     (cmd_w),
        .h     (cmd_h),
        .x_end (w_clip_x_end),
        .y_end (w_clip_y_end),
        .empty (w_clip_empty)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            x0_q    <= x0_d;
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            color_q <= color_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // x_q/y_q always name the pixel currently on the RAM bus, so the
    // registered outputs for the next cycle are derived from the next position.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x0_d     = x0_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        color_d  = color_q;
        addr_d   = addr_q;
        wren_d   = 1'b0;
        done_d   = 1'b0;
        w_accept = cmd_valid && ready_q;
        w_last   = (x_q == x_end_q) && (y_q == y_end_q);

        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    x0_d    = cmd_x0;
                    x_end_d = w_clip_x_end;
                    y_end_d = w_clip_y_end;
                    color_d = cmd_color;
                    x_d     = cmd_x0;
                    y_d     = cmd_y0;
                    if (w_clip_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FILL;
                        wren_d  = 1'b1;
                        addr_d  = {cmd_y0, cmd_x0};
                    end
                end
            end
            FILL: begin
                if (w_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    wren_d = 1'b1;
                    if (x_q == x_end_q) begin
                        x_d = x0_q;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    addr_d = {y_d, x_d};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so that ready stays low throughout reset and rises on
        // the first edge after release.
        ready_d = (state_d == IDLE);
    end

    assign cmd_ready = ready_q;
    assign mem_addr  = addr_q;
    assign mem_data  = color_q;
    assign mem_wren  = wren_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rect_fill_writer.sv
// +----------------------------------------------------------------------+
// | tb_rect_fill_writer : randomized self-checking bench for fill writer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_rect_fill_writer;

    localparam int DW = 16;
    localparam int CW = 8;
    localparam int FB = 256;

    logic          clock     = 1'b0;
    logic          clear_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x0    = '0;
    logic [CW-1:0] cmd_y0    = '0;
    logic [CW-1:0] cmd_w     = '0;
    logic [CW-1:0] cmd_h     = '0;
    logic [DW-1:0] cmd_color = '0;
    logic [2*CW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_wren;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    rect_fill_writer #(
        .DATA_W  (DW),
        .COORD_W (CW)
    ) dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Reference: every on-screen pixel of the rectangle, row by row, left to right.
    function automatic void build_expected(input int x0, input int y0, input int w, input int h);
        exp_q.delete();
        for (int y = y0; y < y0 + h; y++) begin
            if (y < FB) begin
                for (int x = x0; x < x0 + w; x++) begin
                    if (x < FB) exp_q.push_back(y * FB + x);
                end
            end
        end
    endfunction

    task automatic run_cmd(input string name, input int x0, input int y0, input int w, input int h,
                           input logic [DW-1:0] color, input bit hold_next,
                           input int nx0, input int ny0, input int nw, input int nh,
                           input logic [DW-1:0] ncolor);
        int            obs_addr[$];
        int            obs_cyc[$];
        logic [DW-1:0] obs_data[$];
        int            cyc;
        int            done_cyc;
        int            budget;
        int            n;
        int            wait_cnt;
        int            bad_idx;
        bit            busy_bad;
        build_expected(x0, y0, w, h);
        n = exp_q.size();
        wait_cnt = 0;
        while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
            @(negedge clock);
            wait_cnt++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: cmd_ready=%b required 1", name, cmd_ready);
            return;
        end
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        if (hold_next) begin
            cmd_x0    = 8'(nx0);
            cmd_y0    = 8'(ny0);
            cmd_w     = 8'(nw);
            cmd_h     = 8'(nh);
            cmd_color = ncolor;
        end else begin
            cmd_valid = 1'b0;
            cmd_x0    = 8'($urandom);
            cmd_y0    = 8'($urandom);
            cmd_w     = 8'($urandom);
            cmd_h     = 8'($urandom);
            cmd_color = 16'($urandom);
        end

        cyc      = 0;
        done_cyc = -1;
        budget   = n + 8;
        busy_bad = 1'b0;
        while (done_cyc < 0 && cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (mem_wren === 1'b1) begin
                obs_addr.push_back(int'(mem_addr));
                obs_data.push_back(mem_data);
                obs_cyc.push_back(cyc);
            end
            if (done === 1'b1) done_cyc = cyc;
            if (busy !== 1'b1) busy_bad = 1'b1;
        end

        checks++;
        if (done_cyc != n + 1) begin
            errors++;
            $display("FAIL %s done_latency: done at cycle %0d required %0d", name, done_cyc, n + 1);
        end
        checks++;
        if (obs_addr.size() != n) begin
            errors++;
            $display("FAIL %s write_count: got %0d writes required %0d", name, obs_addr.size(), n);
        end
        bad_idx = -1;
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            if (bad_idx < 0 && (obs_addr[i] != exp_q[i] || obs_data[i] !== color || obs_cyc[i] != i + 1))
                bad_idx = i;
        end
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s write_seq[%0d]: addr=%h data=%h cycle=%0d required addr=%h data=%h cycle=%0d",
                     name, bad_idx, obs_addr[bad_idx], obs_data[bad_idx], obs_cyc[bad_idx],
                     exp_q[bad_idx], color, bad_idx + 1);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL %s busy_hold: busy dropped during command, required 1 through done", name);
        end

        @(negedge clock);
        checks++;
        if (done !== 1'b0 || mem_wren !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b wren=%b ready=%b busy=%b required 0 0 1 0",
                     name, done, mem_wren, cmd_ready, busy);
        end
    endtask

    task automatic test_reset();
        clear_n   = 1'b0;
        cmd_valid = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", cmd_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++;
        if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b required 0", mem_wren); end
        checks++;
        if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h required 0", mem_addr); end
        checks++;
        if (mem_data !== '0) begin errors++; $display("FAIL reset_data: got %h required 0", mem_data); end
        cmd_valid = 1'b0;
        clear_n   = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b required 0", cmd_ready); end
        @(posedge clock);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b required 1", cmd_ready); end
        @(negedge clock);
    endtask

    task automatic test_directed();
        run_cmd("basic_3x2", 10, 20, 3, 2, 16'h0F00, 1'b0, 0, 0, 0, 0, '0);
        run_cmd("clip_corner", 254, 255, 5, 4, 16'hA5A5, 1'b0, 0, 0, 0, 0, '0);
        run_cmd("empty_w0", 40, 40, 0, 7, 16'h1234, 1'b0, 0, 0, 0, 0, '0);
        run_cmd("empty_h0", 3, 3, 9, 0, 16'h4321, 1'b0, 0, 0, 0, 0, '0);
    endtask

    task automatic test_back_to_back();
        run_cmd("hold_first", 0, 7, 255, 1, 16'hBEEF, 1'b1, 3, 9, 4, 2, 16'h5A5A);
        run_cmd("hold_second", 3, 9, 4, 2, 16'h5A5A, 1'b0, 0, 0, 0, 0, '0);
    endtask

    task automatic test_abort();
        int  writes;
        int  cyc;
        bit  saw_done;
        writes = 0;
        cyc    = 0;
        saw_done = 1'b0;
        cmd_x0    = 8'd100;
        cmd_y0    = 8'd50;
        cmd_w     = 8'd4;
        cmd_h     = 8'd4;
        cmd_color = 16'hC0DE;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        while (writes < 5 && cyc < 20) begin
            @(negedge clock);
            cyc++;
            if (mem_wren === 1'b1) writes++;
        end
        clear_n = 1'b0;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_async: wren=%b busy=%b after %0d writes, required 0 0", mem_wren, busy, writes);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done === 1'b1 || mem_wren === 1'b1) saw_done = 1'b1;
            if (i == 2) clear_n = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done or wren seen after abort, required none");
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: got %b required 1", cmd_ready);
        end
        run_cmd("after_abort", 100, 50, 4, 4, 16'h0BAD, 1'b0, 0, 0, 0, 0, '0);
    endtask

    task automatic test_random();
        int x0, y0, w, h;
        for (int i = 0; i < 14; i++) begin
            x0 = (i % 2 == 0) ? $urandom_range(245, 255) : $urandom_range(0, 255);
            y0 = (i % 3 == 0) ? $urandom_range(250, 255) : $urandom_range(0, 255);
            w  = $urandom_range(0, 12);
            h  = $urandom_range(0, 6);
            run_cmd($sformatf("random_%0d", i), x0, y0, w, h, 16'($urandom), 1'b0, 0, 0, 0, 0, '0);
        end
    endtask

    task automatic test_full_screen();
        run_cmd("full_255x255", 0, 0, 255, 255, 16'h7E57, 1'b0, 0, 0, 0, 0, '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        test_full_screen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
